// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared constants and types for the board I/O controller.
//   - ADDR_*    : default byte addresses of the mapped registers
//   - *_BITS    : widths of the output registers
//   - state_e   : handshake FSM states
package io_ctrl_pkg;

   localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
   localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
   localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
   localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
   localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

   localparam int HEX_BITS  = 24;
   localparam int LEDR_BITS = 10;
   localparam int LEDG_BITS = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_e;

endpackage : io_ctrl_pkg

// File: rtl/io_debounce.sv
// io_debounce: 2-FF synchronizer followed by a per-bit state register.
// Optional macro IO_CTRL_DEBOUNCE_EN: when defined, each bit only changes
// state after the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   din  [W]     : raw asynchronous inputs
//   dout [W]     : synchronized (and debounced) state
module io_debounce #(
   parameter int W               = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] sync1_r;
   logic [W-1:0] sync2_r;
   logic [W-1:0] state_r;

   // Two-stage synchronizer for the asynchronous inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= {W{1'b0}};
         sync2_r <= {W{1'b0}};
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
      end
   end

`ifdef IO_CTRL_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_r [W];

   // Per-bit stability counter: runs while the input disagrees with the
   // state, and flips the state once it has counted a full window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= {W{1'b0}};
         for (int i = 0; i < W; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else begin
         for (int i = 0; i < W; i++) begin
            if (sync2_r[i] == state_r[i]) begin
               cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] == CW'(DEBOUNCE_CYCLES)) begin
               state_r[i] <= sync2_r[i];
               cnt_r[i]   <= {CW{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CW'(1);
            end
         end
      end
   end
`else
   // Without debounce the state is simply the synchronizer output, registered once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= {W{1'b0}};
      end else begin
         state_r <= sync2_r;
      end
   end
`endif

   assign dout = state_r;

endmodule : io_debounce

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O controller for the processor data port.
// Owns the HEX/LEDR/LEDG output registers and exposes conditioned KEY/SW
// inputs (with sticky press capture on KEY). One-cycle req/ready handshake:
// an access accepted at edge N is acknowledged with ready/hit/rdata in N+1.
// Optional macro IO_CTRL_DEBOUNCE_EN enables input debouncing (io_debounce).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req, we, addr, wdata  : access request, store flag, byte address, store data
//   ready, rdata, hit     : acknowledge, load data, address-mapped flag
//   KEY [4] / SW [10]     : raw push buttons (active-low) and switches
//   hex_out, ledr_out, ledg_out : output registers
module io_ctrl #(
   parameter int               DBITS           = 32,
   parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(io_ctrl_pkg::ADDR_HEX),
   parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(io_ctrl_pkg::ADDR_LEDR),
   parameter logic [DBITS-1:0] ADDR_LEDG       = DBITS'(io_ctrl_pkg::ADDR_LEDG),
   parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(io_ctrl_pkg::ADDR_KEY),
   parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(io_ctrl_pkg::ADDR_SW),
   parameter int               DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req,
   input  logic             we,
   input  logic [DBITS-1:0] addr,
   input  logic [DBITS-1:0] wdata,
   output logic             ready,
   output logic [DBITS-1:0] rdata,
   output logic             hit,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   output logic [23:0]      hex_out,
   output logic [9:0]       ledr_out,
   output logic [7:0]       ledg_out
);

   import io_ctrl_pkg::*;

   state_e                 state_r;
   state_e                 state_nxt_s;
   logic                   ready_r;
   logic                   hit_r;
   logic [DBITS-1:0]       rdata_r;
   logic [HEX_BITS-1:0]    hex_r;
   logic [LEDR_BITS-1:0]   ledr_r;
   logic [LEDG_BITS-1:0]   ledg_r;
   logic [3:0]             key_prev_r;
   logic [3:0]             key_sticky_r;
   logic [3:0]             key_sticky_nxt_s;
   logic [3:0]             key_state_s;
   logic [9:0]             sw_state_s;
   logic                   accept_s;
   logic                   sel_hex_s;
   logic                   sel_ledr_s;
   logic                   sel_ledg_s;
   logic                   sel_key_s;
   logic                   sel_sw_s;
   logic                   mapped_s;
   logic [DBITS-1:0]       rd_mux_s;

   // KEY is inverted before conditioning so a pressed button reads as 1.
   io_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (~KEY),
      .dout    (key_state_s)
   );

   io_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (SW),
      .dout    (sw_state_s)
   );

   // Address decode: full-width equality, so misaligned addresses are unmapped.
   always_comb begin
      sel_hex_s  = (addr == ADDR_HEX);
      sel_ledr_s = (addr == ADDR_LEDR);
      sel_ledg_s = (addr == ADDR_LEDG);
      sel_key_s  = (addr == ADDR_KEY);
      sel_sw_s   = (addr == ADDR_SW);
      mapped_s   = sel_hex_s | sel_ledr_s | sel_ledg_s | sel_key_s | sel_sw_s;
   end

   // Handshake FSM next state; req is only looked at in IDLE.
   always_comb begin
      state_nxt_s = IDLE;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req) begin
               accept_s    = 1'b1;
               state_nxt_s = ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACK:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Load data mux, zero-extended to the bus width.
   always_comb begin
      rd_mux_s = {DBITS{1'b0}};
      if (sel_hex_s) begin
         rd_mux_s = {{(DBITS-HEX_BITS){1'b0}}, hex_r};
      end else if (sel_ledr_s) begin
         rd_mux_s = {{(DBITS-LEDR_BITS){1'b0}}, ledr_r};
      end else if (sel_ledg_s) begin
         rd_mux_s = {{(DBITS-LEDG_BITS){1'b0}}, ledg_r};
      end else if (sel_key_s) begin
         rd_mux_s = {{(DBITS-8){1'b0}}, key_sticky_r, key_state_s};
      end else if (sel_sw_s) begin
         rd_mux_s = {{(DBITS-10){1'b0}}, sw_state_s};
      end else begin
         rd_mux_s = {DBITS{1'b0}};
      end
   end

   // Sticky press capture: a KEY load clears, but a rising edge in the same
   // cycle wins so that press is not lost.
   always_comb begin
      key_sticky_nxt_s = key_sticky_r;
      if (accept_s && !we && sel_key_s) begin
         key_sticky_nxt_s = 4'b0000;
      end else begin
         key_sticky_nxt_s = key_sticky_r;
      end
      key_sticky_nxt_s = key_sticky_nxt_s | (key_state_s & ~key_prev_r);
   end

   // FSM state, acknowledge and load-data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         ready_r <= 1'b0;
         hit_r   <= 1'b0;
         rdata_r <= {DBITS{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         ready_r <= accept_s;
         hit_r   <= accept_s & mapped_s;
         rdata_r <= (accept_s && !we) ? rd_mux_s : {DBITS{1'b0}};
      end
   end

   // Output registers and KEY edge-capture state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_r        <= {HEX_BITS{1'b0}};
         ledr_r       <= {LEDR_BITS{1'b0}};
         ledg_r       <= {LEDG_BITS{1'b0}};
         key_prev_r   <= 4'b0000;
         key_sticky_r <= 4'b0000;
      end else begin
         if (accept_s && we && sel_hex_s) begin
            hex_r <= wdata[HEX_BITS-1:0];
         end
         if (accept_s && we && sel_ledr_s) begin
            ledr_r <= wdata[LEDR_BITS-1:0];
         end
         if (accept_s && we && sel_ledg_s) begin
            ledg_r <= wdata[LEDG_BITS-1:0];
         end
         key_prev_r   <= key_state_s;
         key_sticky_r <= key_sticky_nxt_s;
      end
   end

   assign ready    = ready_r;
   assign hit      = hit_r;
   assign rdata    = rdata_r;
   assign hex_out  = hex_r;
   assign ledr_out = ledr_r;
   assign ledg_out = ledg_r;

endmodule : io_ctrl

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed, table-driven bench for io_ctrl, plus hand-written
// sequences for KEY sticky capture, back-to-back requests and reset mid-access.
// With IO_CTRL_DEBOUNCE_EN defined it also checks glitch filtering (8 cycles).
module tb_io_ctrl;

   logic        clk;
   logic        reset_n;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        hit;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [23:0] hex_out;
   logic [9:0]  ledr_out;
   logic [7:0]  ledg_out;

   int checks;
   int failures;

   io_ctrl #(.DEBOUNCE_CYCLES(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .rdata    (rdata),
      .hit      (hit),
      .KEY      (KEY),
      .SW       (SW),
      .hex_out  (hex_out),
      .ledr_out (ledr_out),
      .ledg_out (ledg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      logic [23:0] exp_hex;
      logic [9:0]  exp_ledr;
      logic [7:0]  exp_ledg;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One access: request at a negedge, check the ACK cycle, then check ready drops.
   task automatic do_access(input string name, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic exp_hit,
                            input logic [31:0] exp_rdata);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      req = 1'b0;
      check({name, ".ready"}, {31'd0, ready}, 32'd1);
      check({name, ".hit"}, {31'd0, hit}, {31'd0, exp_hit});
      check({name, ".rdata"}, rdata, exp_rdata);
      @(posedge clk);
      #1;
      check({name, ".ready_drop"}, {31'd0, ready}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      req      = 1'b0;
      we       = 1'b0;
      addr     = 32'd0;
      wdata    = 32'd0;
      KEY      = 4'hF;
      SW       = 10'h2A5;

      vecs[0]  = '{"st_hex",     1'b1, 32'hF000_0000, 32'h00AB_CDEF, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h000, 8'h00};
      vecs[1]  = '{"ld_hex",     1'b0, 32'hF000_0000, 32'h0000_0000, 1'b1, 32'h00AB_CDEF, 24'hABCDEF, 10'h000, 8'h00};
      vecs[2]  = '{"st_ledr",    1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'h00};
      vecs[3]  = '{"ld_ledr",    1'b0, 32'hF000_0004, 32'h0000_0000, 1'b1, 32'h0000_03FF, 24'hABCDEF, 10'h3FF, 8'h00};
      vecs[4]  = '{"st_ledg",    1'b1, 32'hF000_0008, 32'h1234_55A5, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[5]  = '{"ld_ledg",    1'b0, 32'hF000_0008, 32'h0000_0000, 1'b1, 32'h0000_00A5, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[6]  = '{"ld_misalign",1'b0, 32'hF000_0002, 32'h0000_0000, 1'b0, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[7]  = '{"ld_far",     1'b0, 32'h0000_1000, 32'h0000_0000, 1'b0, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[8]  = '{"st_misalign",1'b1, 32'hF000_0006, 32'h0000_0000, 1'b0, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[9]  = '{"st_hole",    1'b1, 32'hF000_000C, 32'h0000_0000, 1'b0, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[10] = '{"st_key",     1'b1, 32'hF000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[11] = '{"st_sw",      1'b1, 32'hF000_0014, 32'h0000_0000, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[12] = '{"ld_sw",      1'b0, 32'hF000_0014, 32'h0000_0000, 1'b1, 32'h0000_02A5, 24'hABCDEF, 10'h3FF, 8'hA5};
      vecs[13] = '{"ld_key_idle",1'b0, 32'hF000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000, 24'hABCDEF, 10'h3FF, 8'hA5};

      repeat (3) @(posedge clk);
      #1;
      check("rst.ready", {31'd0, ready}, 32'd0);
      check("rst.hit", {31'd0, hit}, 32'd0);
      check("rst.rdata", rdata, 32'd0);
      check("rst.hex", {8'd0, hex_out}, 32'd0);
      check("rst.ledr", {22'd0, ledr_out}, 32'd0);
      check("rst.ledg", {24'd0, ledg_out}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(posedge clk);

      // Table-driven accesses
      for (int i = 0; i < 14; i++) begin
         do_access(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_hit, vecs[i].exp_rdata);
         check({vecs[i].name, ".hex"}, {8'd0, hex_out}, {8'd0, vecs[i].exp_hex});
         check({vecs[i].name, ".ledr"}, {22'd0, ledr_out}, {22'd0, vecs[i].exp_ledr});
         check({vecs[i].name, ".ledg"}, {24'd0, ledg_out}, {24'd0, vecs[i].exp_ledg});
      end

      // KEY[2] press and release: sticky only
      @(negedge clk); KEY = 4'b1011;
      repeat (20) @(posedge clk);
      @(negedge clk); KEY = 4'b1111;
      repeat (20) @(posedge clk);
      do_access("key_sticky", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0040);
      do_access("key_cleared", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0000);
      // Press again and hold: first load sees sticky + state, second only state
      @(negedge clk); KEY = 4'b1011;
      repeat (20) @(posedge clk);
      do_access("key_press_hold", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0044);
      do_access("key_held", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0004);
      @(negedge clk); KEY = 4'b1111;
      repeat (20) @(posedge clk);
      do_access("key_released", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0000);

`ifndef IO_CTRL_DEBOUNCE_EN
      // Rising edge lands on the same edge as the clearing load: the load sees
      // state only, and the sticky bit survives for the next load.
      @(negedge clk); KEY = 4'b1110;
      @(negedge clk);
      @(negedge clk);
      do_access("key_clear_race", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0001);
      do_access("key_race_kept", 1'b0, 32'hF000_0010, 32'd0, 1'b1, 32'h0000_0011);
      @(negedge clk); KEY = 4'b1111;
      repeat (20) @(posedge clk);
`else
      // Debounce: short glitch filtered, long hold accepted
      @(negedge clk); SW = 10'h000;
      repeat (30) @(posedge clk);
      do_access("db_sw_low", 1'b0, 32'hF000_0014, 32'd0, 1'b1, 32'h0000_0000);
      @(negedge clk); SW = 10'h001;
      repeat (5) @(negedge clk);
      SW = 10'h000;
      repeat (30) @(posedge clk);
      do_access("db_glitch", 1'b0, 32'hF000_0014, 32'd0, 1'b1, 32'h0000_0000);
      @(negedge clk); SW = 10'h001;
      repeat (12) @(negedge clk);
      do_access("db_hold", 1'b0, 32'hF000_0014, 32'd0, 1'b1, 32'h0000_0001);
`endif

      // Held req: accepted every other cycle
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'hF000_0000;
      @(posedge clk); #1;
      check("b2b.ready1", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      check("b2b.ready_gap", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
      check("b2b.ready2", {31'd0, ready}, 32'd1);
      check("b2b.rdata2", rdata, 32'h00AB_CDEF);
      req = 1'b0;
      @(posedge clk); #1;
      check("b2b.idle", {31'd0, ready}, 32'd0);

      // Reset in the ACK cycle of a HEX load
      do_access("st_hex2", 1'b1, 32'hF000_0000, 32'h0012_3456, 1'b1, 32'h0000_0000);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'hF000_0000;
      @(posedge clk); #1;
      req = 1'b0;
      check("rstack.pre_ready", {31'd0, ready}, 32'd1);
      check("rstack.pre_rdata", rdata, 32'h0012_3456);
      #1;
      reset_n = 1'b0;
      #1;
      check("rstack.ready", {31'd0, ready}, 32'd0);
      check("rstack.hex", {8'd0, hex_out}, 32'd0);
      check("rstack.rdata", rdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rstack.no_retry", {31'd0, ready}, 32'd0);
      do_access("rstack.ld_hex", 1'b0, 32'hF000_0000, 32'd0, 1'b1, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_io_ctrl
